// File: rtl/meas_sequencer_pkg.sv
// Shared types and sizing helpers for the wave-measurement sequencer.
package meas_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SETTLE,
    ACQ,
    WAIT,
    OUTPUT
  } meas_state_e;

  localparam int N_DEF      = 8;
  localparam int FREQ_W_DEF = 16;

  // One counter serves settle, window and timeout phases, so size it for the largest.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m > 0) ? $clog2(m + 1) : 1;
  endfunction

endpackage

// File: rtl/meas_sequencer_if.sv
// Result handshake bundle: captured measurement plus valid/ready.
interface meas_sequencer_if #(
  parameter int N      = meas_pkg::N_DEF,
  parameter int FREQ_W = meas_pkg::FREQ_W_DEF
);
  logic [N-1:0]      res_vpp;
  logic [7:0]        res_papr;
  logic              res_is_sine;
  logic [FREQ_W-1:0] res_freq;
  logic              res_valid;
  logic              res_ready;

  modport master (
    output res_vpp, res_papr, res_is_sine, res_freq, res_valid,
    input  res_ready
  );

  modport slave (
    input  res_vpp, res_papr, res_is_sine, res_freq, res_valid,
    output res_ready
  );
endinterface

// File: rtl/meas_sequencer_tick_gen.sv
// Free-running divider: one-cycle sample_en_o every FRE_DIV+1 clocks (constant 1 when FRE_DIV=0).
module sample_tick_gen #(
  parameter int FRE_DIV = 2499
) (
  input  logic clk,
  input  logic rst,
  output logic sample_en_o
);
  localparam int            CW   = (FRE_DIV > 0) ? $clog2(FRE_DIV + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRE_DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          en_q;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

  // Registered strobe keeps the output low during reset even when FRE_DIV=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      en_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      en_q  <= (cnt_d == LAST);
    end
  end

  assign sample_en_o = en_q;
endmodule

// File: rtl/meas_sequencer.sv
// Sequencer for the wave-measurement datapath: clear, settle, window, capture, hand off.
// Build option MEAS_SEQ_TIMEOUT_EN bounds the wait for dp_done and drives timeout_err.
module meas_sequencer
  import meas_pkg::*;
#(
  parameter int N               = N_DEF,
  parameter int FREQ_W          = FREQ_W_DEF,
  parameter int FRE_DIV         = 2499,
  parameter int SETTLE_SAMPLES  = 64,
  parameter int WINDOW_SAMPLES  = 2048,
  parameter int MIN_VPP         = 8,
  parameter int TIMEOUT_SAMPLES = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              continuous,
  input  logic              abort,
  output logic              sample_en,
  output logic              dp_clear,
  output logic              dp_acq,
  input  logic              dp_done,
  input  logic [N-1:0]      dp_vpp,
  input  logic [7:0]        dp_papr,
  input  logic              dp_is_sine,
  input  logic [FREQ_W-1:0] dp_freq,
  meas_sequencer_if.master  res,
  output logic              ma_enable,
  output logic              busy,
  output logic              timeout_err
);
  localparam int               CNT_W       = cnt_width(SETTLE_SAMPLES, WINDOW_SAMPLES, TIMEOUT_SAMPLES);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE_SAMPLES > 0) ? SETTLE_SAMPLES - 1 : 0);
  localparam logic [CNT_W-1:0] WINDOW_LAST = CNT_W'(WINDOW_SAMPLES - 1);
  localparam logic [N-1:0]     MIN_VPP_N   = N'(MIN_VPP);
`ifdef MEAS_SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'((TIMEOUT_SAMPLES > 0) ? TIMEOUT_SAMPLES - 1 : 0);
  logic timeout_hit;
  logic terr_q;
`endif

  meas_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              dp_acq_q;
  logic              capture, handshake, capture_ok;
  logic              ma_q, prev_ok_q;
  logic [N-1:0]      res_vpp_q;
  logic [7:0]        res_papr_q;
  logic              res_is_sine_q;
  logic [FREQ_W-1:0] res_freq_q;

  sample_tick_gen #(.FRE_DIV(FRE_DIV)) u_tick (
    .clk        (clk),
    .rst        (rst),
    .sample_en_o(sample_en)
  );

  assign handshake  = (state_q == OUTPUT) && res.res_ready;
  assign capture    = (state_q == WAIT) && dp_done && !abort;
  assign capture_ok = dp_is_sine && (dp_vpp >= MIN_VPP_N);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef MEAS_SEQ_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    case (state_q)
      IDLE: if (start || continuous) state_d = CLEAR;
      CLEAR: begin
        cnt_d   = '0;
        state_d = (SETTLE_SAMPLES == 0) ? ACQ : SETTLE;
      end
      SETTLE: if (sample_en) begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = ACQ;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ACQ: if (sample_en) begin
        if (cnt_q == WINDOW_LAST) begin
          cnt_d   = '0;
          state_d = WAIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT: begin
        if (dp_done) begin
          state_d = OUTPUT;
        end
`ifdef MEAS_SEQ_TIMEOUT_EN
        else if (sample_en) begin
          if (cnt_q == TIMEOUT_LAST) begin
            timeout_hit = 1'b1;
            cnt_d       = '0;
            state_d     = continuous ? CLEAR : IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`endif
      end
      OUTPUT: if (handshake) state_d = continuous ? CLEAR : IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  always_comb begin
    dp_clear      = (state_q == CLEAR);
    busy          = (state_q != IDLE);
    res.res_valid = (state_q == OUTPUT);
  end

  // Window flag is registered from the next state so it tracks ACQ without a combinational path.
  always_ff @(posedge clk) begin
    if (rst) dp_acq_q <= 1'b0;
    else     dp_acq_q <= (state_d == ACQ);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_vpp_q     <= '0;
      res_papr_q    <= '0;
      res_is_sine_q <= 1'b0;
      res_freq_q    <= '0;
    end else if (capture) begin
      res_vpp_q     <= dp_vpp;
      res_papr_q    <= dp_papr;
      res_is_sine_q <= dp_is_sine;
      res_freq_q    <= dp_freq;
    end
  end

  // Modulation depth is only trusted after two consecutive stable sine captures.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      ma_q      <= 1'b0;
      prev_ok_q <= 1'b0;
    end else if (capture) begin
      ma_q      <= capture_ok && prev_ok_q;
      prev_ok_q <= capture_ok;
    end
  end

`ifdef MEAS_SEQ_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst)                                        terr_q <= 1'b0;
    else if (timeout_hit && !abort)                 terr_q <= 1'b1;
    else if ((state_q == IDLE) && start && !abort) terr_q <= 1'b0;
  end
  assign timeout_err = terr_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign dp_acq          = dp_acq_q;
  assign ma_enable       = ma_q;
  assign res.res_vpp     = res_vpp_q;
  assign res.res_papr    = res_papr_q;
  assign res.res_is_sine = res_is_sine_q;
  assign res.res_freq    = res_freq_q;
endmodule

// File: tb/tb_meas_sequencer.sv
// Bench for meas_sequencer: table-driven measurements, corner sequences, randomized runs.
module tb_meas_sequencer;
  import meas_pkg::*;

  localparam int N  = 8;
  localparam int FW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, continuous, abort, dp_done;
  logic [N-1:0]  dp_vpp;
  logic [7:0]    dp_papr;
  logic          dp_is_sine;
  logic [FW-1:0] dp_freq;
  logic          sample_en, dp_clear, dp_acq, ma_enable, busy, timeout_err;

  logic b_start, b_cont, b_abort, b_done;
  logic b_sample_en, b_clear, b_acq, b_ma, b_busy, b_terr;

  meas_sequencer_if #(.N(N), .FREQ_W(FW)) rif ();
  meas_sequencer_if #(.N(N), .FREQ_W(FW)) bif ();

  meas_sequencer #(
    .N(N), .FREQ_W(FW), .FRE_DIV(3), .SETTLE_SAMPLES(2), .WINDOW_SAMPLES(8),
    .MIN_VPP(8), .TIMEOUT_SAMPLES(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous), .abort(abort),
    .sample_en(sample_en), .dp_clear(dp_clear), .dp_acq(dp_acq), .dp_done(dp_done),
    .dp_vpp(dp_vpp), .dp_papr(dp_papr), .dp_is_sine(dp_is_sine), .dp_freq(dp_freq),
    .res(rif), .ma_enable(ma_enable), .busy(busy), .timeout_err(timeout_err)
  );

  meas_sequencer #(
    .N(N), .FREQ_W(FW), .FRE_DIV(0), .SETTLE_SAMPLES(2), .WINDOW_SAMPLES(8),
    .MIN_VPP(8), .TIMEOUT_SAMPLES(4)
  ) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .continuous(b_cont), .abort(b_abort),
    .sample_en(b_sample_en), .dp_clear(b_clear), .dp_acq(b_acq), .dp_done(b_done),
    .dp_vpp(dp_vpp), .dp_papr(dp_papr), .dp_is_sine(dp_is_sine), .dp_freq(dp_freq),
    .res(bif), .ma_enable(b_ma), .busy(b_busy), .timeout_err(b_terr)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Divider reference: edges since reset release, sampled on the falling edge.
  logic rst_s;
  int   se_k = 0;
  always @(posedge clk) rst_s <= rst;
  always @(negedge clk) begin
    if (rst_s === 1'b1) se_k = 0;
    else                se_k++;
    if (rst_s === 1'b0 || rst_s === 1'b1) begin
      chk("sample_en div4", sample_en, (rst_s == 1'b0) && (se_k % 4 == 3));
      chk("sample_en div1", b_sample_en, (rst_s == 1'b0) && (se_k >= 1));
    end
  end

  // ma_enable reference: two consecutive qualifying captures.
  bit mdl_prev = 0;
  function automatic logic mdl_ma(input logic [7:0] v, input logic s);
    logic ok;
    ok       = s && (v >= 8);
    mdl_ma   = ok && mdl_prev;
    mdl_prev = ok;
  endfunction

  typedef struct {
    logic [7:0]  vpp;
    logic [7:0]  papr;
    logic        sine;
    logic [15:0] freq;
    int          hold;
    logic        exp_ma;
  } vec_t;
  vec_t tbl[6];

  task automatic do_meas(input logic [7:0] vpp, input logic [7:0] papr, input logic sine,
                         input logic [15:0] freq, input int hold, input logic exp_ma,
                         input logic cont_after, input bit poke);
    int         n;
    logic [7:0] old_vpp;
    logic       prev_se;
    n = 0;
    while (!dp_clear && n < 20) begin step(); n++; end
    chk("dp_clear seen", dp_clear, 1);
    step();
    chk("dp_clear one cycle", dp_clear, 0);
    old_vpp = rif.res_vpp;
    n = 0;
    while (!dp_acq && n < 40) begin
      if (poke && n == 0) begin dp_vpp = ~old_vpp; dp_done = 1'b1; end
      step(); n++;
      if (poke && n == 1) begin
        dp_done = 1'b0;
        chk("done in SETTLE vpp", rif.res_vpp, old_vpp);
        chk("done in SETTLE valid", rif.res_valid, 0);
        chk("done in SETTLE busy", busy, 1);
      end
    end
    chk("dp_acq rose", dp_acq, 1);
    n = 0; prev_se = 1'b0;
    while (dp_acq && n < 100) begin
      if (poke && n == 5) start = 1'b1;
      prev_se = sample_en;
      step(); n++;
      start = 1'b0;
    end
    chk("window length", n, 32);
    chk("acq drop after last sample", prev_se, 1);
    chk("busy in WAIT", busy, 1);
    dp_vpp = vpp; dp_papr = papr; dp_is_sine = sine; dp_freq = freq; dp_done = 1'b1;
    if (hold > 0) rif.res_ready = 1'b0;
    step();
    dp_done = 1'b0;
    chk("valid after done", rif.res_valid, 1);
    chk("res_vpp", rif.res_vpp, vpp);
    chk("res_papr", rif.res_papr, papr);
    chk("res_is_sine", rif.res_is_sine, sine);
    chk("res_freq", rif.res_freq, freq);
    chk("ma_enable", ma_enable, exp_ma);
    for (int i = 0; i < hold; i++) begin
      dp_vpp = $urandom; dp_papr = $urandom; dp_is_sine = ~sine; dp_freq = $urandom;
      dp_done = i[0];
      step();
      chk("hold valid", rif.res_valid, 1);
      chk("hold vpp", rif.res_vpp, vpp);
      chk("hold freq", rif.res_freq, freq);
    end
    dp_done = 1'b0;
    rif.res_ready = 1'b1;
    step();
    chk("valid drop after handshake", rif.res_valid, 0);
    chk("res_vpp retained", rif.res_vpp, vpp);
    chk("busy after handshake", busy, cont_after);
    chk("dp_clear after handshake", dp_clear, cont_after);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n, k;
    logic [7:0] v, saved;
    logic       s, rv;

    tbl[0] = '{8'd50,  8'd141, 1'b1, 16'd5000,  0, 1'b0};
    tbl[1] = '{8'd50,  8'd141, 1'b1, 16'd5000,  3, 1'b1};
    tbl[2] = '{8'd80,  8'd100, 1'b0, 16'd7000,  0, 1'b0};
    tbl[3] = '{8'd7,   8'd90,  1'b1, 16'd100,   0, 1'b0};
    tbl[4] = '{8'd8,   8'd90,  1'b1, 16'd200,   2, 1'b0};
    tbl[5] = '{8'd255, 8'd60,  1'b1, 16'd65535, 0, 1'b1};

    rst = 1'b1; start = 1'b0; continuous = 1'b0; abort = 1'b0; dp_done = 1'b0;
    dp_vpp = '0; dp_papr = '0; dp_is_sine = 1'b0; dp_freq = '0;
    b_start = 1'b0; b_cont = 1'b0; b_abort = 1'b0; b_done = 1'b0;
    rif.res_ready = 1'b1; bif.res_ready = 1'b1;
    repeat (3) step();
    chk("rst dp_clear", dp_clear, 0);
    chk("rst dp_acq", dp_acq, 0);
    chk("rst res_valid", rif.res_valid, 0);
    chk("rst res_vpp", rif.res_vpp, 0);
    chk("rst res_freq", rif.res_freq, 0);
    chk("rst ma_enable", ma_enable, 0);
    chk("rst busy", busy, 0);
    chk("rst timeout_err", timeout_err, 0);
    rst = 1'b0;
    step();

    // Single shot
    start = 1'b1; step(); start = 1'b0;
    chk("start->dp_clear", dp_clear, 1);
    do_meas(8'd50, 8'd141, 1'b1, 16'd5000, 0, mdl_ma(8'd50, 1'b1), 1'b0, 1'b0);

    // Backpressure
    start = 1'b1; step(); start = 1'b0;
    do_meas(8'd120, 8'd200, 1'b1, 16'd1234, 20, mdl_ma(8'd120, 1'b1), 1'b0, 1'b0);
    saved = 8'd120;

    // Abort on the 4th window sample
    start = 1'b1; step(); start = 1'b0;
    n = 0;
    while (!dp_acq && n < 40) begin step(); n++; end
    n = 0; k = 0;
    while (n < 4 && k < 100) begin
      if (sample_en) n++;
      if (n < 4) begin step(); k++; end
    end
    chk("abort 4 samples", n, 4);
    abort = 1'b1; step(); abort = 1'b0;
    mdl_prev = 0;
    chk("abort busy", busy, 0);
    chk("abort dp_acq", dp_acq, 0);
    chk("abort res_valid", rif.res_valid, 0);
    chk("abort ma_enable", ma_enable, 0);
    repeat (5) step();
    dp_vpp = 8'd3; dp_done = 1'b1; step(); dp_done = 1'b0;
    chk("late done vpp kept", rif.res_vpp, saved);
    chk("late done valid", rif.res_valid, 0);
    chk("late done busy", busy, 0);
    start = 1'b1; abort = 1'b1; step(); start = 1'b0; abort = 1'b0;
    chk("start+abort busy", busy, 0);
    chk("start+abort clear", dp_clear, 0);

    // Continuous table, continuous dropped during the last run
    continuous = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) continuous = 1'b0;
      s = mdl_ma(tbl[i].vpp, tbl[i].sine);
      do_meas(tbl[i].vpp, tbl[i].papr, tbl[i].sine, tbl[i].freq, tbl[i].hold,
              tbl[i].exp_ma, (i < 5), 1'b0);
    end

    // Ignored inputs: dp_done in SETTLE, start in ACQ
    start = 1'b1; step(); start = 1'b0;
    do_meas(8'd33, 8'd77, 1'b1, 16'd4242, 1, mdl_ma(8'd33, 1'b1), 1'b0, 1'b1);

    // Randomized single shots against the reference model
    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(0, 3))
        0: v = 8'd7;
        1: v = 8'd8;
        2: v = 8'd9;
        default: v = 8'($urandom);
      endcase
      s = 1'($urandom);
      repeat ($urandom_range(0, 5)) step();
      start = 1'b1; step(); start = 1'b0;
      chk("rand start->dp_clear", dp_clear, 1);
      do_meas(v, 8'($urandom), s, 16'($urandom), $urandom_range(0, 4), mdl_ma(v, s), 1'b0, 1'b0);
    end

    // FRE_DIV=0 instance: window is 8 clocks
    b_start = 1'b1; step(); b_start = 1'b0;
    chk("div1 dp_clear", b_clear, 1);
    n = 0;
    while (!b_acq && n < 20) begin step(); n++; end
    chk("div1 settle cycles", n, 3);
    n = 0;
    while (b_acq && n < 40) begin step(); n++; end
    chk("div1 window length", n, 8);
    dp_vpp = 8'd99; dp_papr = 8'd11; dp_is_sine = 1'b1; dp_freq = 16'd777; b_done = 1'b1;
    step(); b_done = 1'b0;
    chk("div1 valid", bif.res_valid, 1);
    chk("div1 res_freq", bif.res_freq, 777);
    step();
    chk("div1 valid drop", bif.res_valid, 0);
    chk("div1 busy", b_busy, 0);

    // Wait with no dp_done
    start = 1'b1; step(); start = 1'b0;
    n = 0;
    while (!dp_acq && n < 40) begin step(); n++; end
    n = 0;
    while (dp_acq && n < 100) begin step(); n++; end
`ifdef MEAS_SEQ_TIMEOUT_EN
    n = 0; k = 0; rv = 1'b0;
    while (busy && k < 60) begin
      if (sample_en) n++;
      if (rif.res_valid) rv = 1'b1;
      step(); k++;
    end
    chk("timeout idle", busy, 0);
    chk("timeout samples", n, 4);
    chk("timeout_err set", timeout_err, 1);
    chk("timeout no valid", rv, 0);
    start = 1'b1; step(); start = 1'b0;
    chk("timeout_err cleared", timeout_err, 0);
    chk("restart clear", dp_clear, 1);
    abort = 1'b1; step(); abort = 1'b0;
    mdl_prev = 0;
`else
    repeat (30) step();
    chk("wait holds busy", busy, 1);
    chk("timeout_err tied", timeout_err, 0);
    chk("wait no valid", rif.res_valid, 0);
    abort = 1'b1; step(); abort = 1'b0;
    mdl_prev = 0;
    chk("wait abort busy", busy, 0);
`endif

    repeat (2) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
